// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding request to instruction memory,
// one-entry holding buffer toward decode, redirect handling with stale-response discard.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    // state | meaning
    // REQ   | request for pc presented to memory
    // WAIT  | request accepted, waiting for the response word
    // HOLD  | fetched word presented to decode until consumed
    // FAULT | misaligned redirect seen; idle until reset
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        discard_q, discard_d;
    logic        fault_q, fault_d;
    logic        run_q;

    logic        redir_ok;
    logic        redir_bad;
    logic        req_fire;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign req_fire  = (state_q == S_REQ) && run_q && imem_req_ready;

    // run_q keeps the request line low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            pc_out_q  <= 32'h0;
            discard_q <= 1'b0;
            fault_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            discard_q <= discard_d;
            fault_q   <= fault_d;
            run_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        discard_d = discard_q;
        fault_d   = fault_q;

        case (state_q)
            S_REQ: begin
                if (redir_bad) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else if (redir_ok) begin
                    pc_d = redirect_pc;
                    if (req_fire) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir_bad) begin
                    state_d   = S_FAULT;
                    fault_d   = 1'b1;
                    discard_d = 1'b0;
                end else if (redir_ok) begin
                    pc_d = redirect_pc;
                    // a response landing in the redirect cycle belongs to the old path
                    if (imem_resp_valid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (discard_q) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        state_d  = S_HOLD;
                        instr_d  = imem_resp_data;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                    end
                end
            end
            S_HOLD: begin
                if (redir_bad) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else if (redir_ok) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    state_d = S_REQ;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == S_REQ) && run_q;
        imem_addr      = pc_q;
        instr_valid    = (state_q == S_HOLD);
        instruction    = instr_q;
        pc_out         = pc_out_q;
        fetch_fault    = fault_q;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural memory, random redirect/back-pressure stimulus,
// and a scoreboard holding the address the next delivered instruction must come from.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_fault;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instruction    (instruction),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;

    // stimulus knobs
    int          ready_pct  = 100;
    int          iready_pct = 100;
    int          redir_pct  = 0;
    int          spur_pct   = 0;
    int          lat_min    = 1;
    int          lat_max    = 1;
    int          rst_cnt    = 3;
    bit          fr_valid   = 1'b0;
    logic [31:0] fr_pc      = 32'h0;

    // memory model
    bit          acc = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    // reference model
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_fault = 1'b0;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_accept(output logic [31:0] addr, output bit ok, output int nval);
        ok = 1'b0;
        nval = 0;
        addr = 32'h0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                addr = imem_addr;
                ok = 1'b1;
                return;
            end
            if (rst_n && instr_valid) nval++;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rst_n && instr_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // input driver and memory responder, just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_cnt > 0) begin
                rst_n = 1'b0;
                rst_cnt--;
            end else begin
                rst_n = 1'b1;
            end
            if (acc) begin
                pending  = 1'b1;
                cnt      = $urandom_range(lat_min, lat_max);
                mem_addr = acc_addr;
            end
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = word(mem_addr);
                    pending         = 1'b0;
                end
            end else if (rst_n && (imem_req_valid || instr_valid || fetch_fault) &&
                         ($urandom_range(0, 99) < spur_pct)) begin
                imem_resp_valid = 1'b1;
            end
            imem_req_ready = !pending && ($urandom_range(0, 99) < ready_pct);
            instr_ready    = ($urandom_range(0, 99) < iready_pct);
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
            if (fr_valid) begin
                redirect_valid = 1'b1;
                redirect_pc    = fr_pc;
                fr_valid       = 1'b0;
            end else if (rst_n && ($urandom_range(0, 99) < redir_pct)) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 29) == 0) begin
                    if (redirect_pc[1:0] == 2'b00) redirect_pc[0] = 1'b1;
                end else if ($urandom_range(0, 9) == 0) begin
                    redirect_pc = 32'hFFFF_FFFC;
                end else begin
                    redirect_pc = 32'($urandom_range(0, 255)) << 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        acc      = rst_n && imem_req_valid && imem_req_ready;
        acc_addr = imem_addr;
    end

    // reference model: which pc must the next instruction handed to decode carry
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                m_pc    = RESET_PC;
                m_fault = 1'b0;
                exp_q.delete();
                exp_q.push_back(m_pc);
            end else if (!m_fault) begin
                if (instr_valid && instr_ready) begin
                    m_pc = m_pc + 32'd4;
                    exp_q.delete();
                    exp_q.push_back(m_pc);
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    if (redirect_pc[1:0] == 2'b00) begin
                        m_pc = redirect_pc;
                        exp_q.push_back(m_pc);
                    end else begin
                        m_fault = 1'b1;
                    end
                end
            end
        end
    end

    // monitor
    bit          prev_stall = 1'b0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_pc    = 32'h0;

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
                chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
                chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
                chk("rst_instruction", instruction, 32'h0);
                chk("rst_pc_out", pc_out, 32'h0);
                prev_stall = 1'b0;
            end else begin
                chk("fault_flag", {31'h0, fetch_fault}, {31'h0, m_fault});
                if (m_fault) begin
                    chk("fault_no_req", {31'h0, imem_req_valid}, 32'h0);
                    chk("fault_no_valid", {31'h0, instr_valid}, 32'h0);
                end
                chk("one_outstanding", {31'h0, imem_req_valid && instr_valid}, 32'h0);
                if (prev_stall) begin
                    chk("hold_valid", {31'h0, instr_valid}, 32'h1);
                    chk("hold_instr", instruction, prev_instr);
                    chk("hold_pc", pc_out, prev_pc);
                end
                if (instr_valid && instr_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL xfer_unexpected: got pc %h, none expected (t=%0t)", pc_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_pc", pc_out, e);
                        chk("xfer_instr", instruction, word(e));
                    end
                end
                prev_stall = instr_valid && !instr_ready && !redirect_valid;
                prev_instr = instruction;
                prev_pc    = pc_out;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // directed scenarios, then randomized traffic
    initial begin
        logic [31:0] a;
        logic [31:0] p;
        bit          ok;
        int          nv;
        int          fault_cyc;
        int          xfer_start;

        // basic fetch, latency and throughput
        wait_accept(a, ok, nv);
        chk("first_accept", {31'h0, ok}, 32'h1);
        chk("first_addr", a, RESET_PC);
        @(negedge clk);
        chk("lat_wait_novalid", {31'h0, instr_valid}, 32'h0);
        @(negedge clk);
        chk("lat_valid", {31'h0, instr_valid}, 32'h1);
        chk("lat_instr", instruction, 32'h0050_0093);
        chk("lat_pc_out", pc_out, 32'h0);
        @(negedge clk);
        chk("next_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("next_req_addr", imem_addr, 32'h4);

        // back-pressure in HOLD
        iready_pct = 0;
        wait_valid(ok);
        chk("stall_valid_seen", {31'h0, ok}, 32'h1);
        p = pc_out;
        chk("stall_pc", p, 32'h4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
            chk("stall_valid", {31'h0, instr_valid}, 32'h1);
        end
        iready_pct = 100;
        @(negedge clk);
        @(negedge clk);
        chk("after_stall_req", {31'h0, imem_req_valid}, 32'h1);
        chk("after_stall_addr", imem_addr, p + 32'd4);

        // redirect while waiting for the response
        lat_min = 3;
        lat_max = 3;
        wait_accept(a, ok, nv);
        fr_pc = 32'h0000_0100;
        fr_valid = 1'b1;
        wait_accept(a, ok, nv);
        chk("redir_wait_accept", {31'h0, ok}, 32'h1);
        chk("redir_wait_addr", a, 32'h0000_0100);
        chk("redir_wait_dropped", nv, 0);
        lat_min = 1;
        lat_max = 1;

        // wrap at the top of the address space
        wait_accept(a, ok, nv);
        fr_pc = 32'hFFFF_FFFC;
        fr_valid = 1'b1;
        wait_accept(a, ok, nv);
        chk("wrap_addr_top", a, 32'hFFFF_FFFC);
        chk("wrap_dropped", nv, 0);
        wait_accept(a, ok, nv);
        chk("wrap_addr_zero", a, 32'h0);
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap_delivered", nv, 1);

        // misaligned redirect, then recovery by reset
        fr_pc = 32'h0000_0102;
        fr_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fault_set", {31'h0, fetch_fault}, 32'h1);
            chk("fault_req_low", {31'h0, imem_req_valid}, 32'h0);
        end
        rst_cnt = 2;
        wait_accept(a, ok, nv);
        chk("fault_restart_addr", a, RESET_PC);
        chk("fault_cleared", {31'h0, fetch_fault}, 32'h0);

        // reset during WAIT with a late response
        lat_min = 3;
        lat_max = 3;
        wait_accept(a, ok, nv);
        chk("late_pre_addr", a, 32'h4);
        rst_cnt = 2;
        wait_accept(a, ok, nv);
        chk("late_restart_addr", a, RESET_PC);
        chk("late_no_valid", nv, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_still_no_valid", {31'h0, instr_valid}, 32'h0);
        end

        // randomized traffic
        ready_pct  = 70;
        iready_pct = 70;
        redir_pct  = 8;
        spur_pct   = 20;
        lat_min    = 1;
        lat_max    = 3;
        fault_cyc  = 0;
        xfer_start = n_xfer;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (fetch_fault && rst_cnt == 0) begin
                fault_cyc++;
                if (fault_cyc >= 4) begin
                    rst_cnt = 2;
                    fault_cyc = 0;
                end
            end else if (rst_cnt == 0 && $urandom_range(0, 399) == 0) begin
                rst_cnt = $urandom_range(1, 3);
            end
        end
        redir_pct  = 0;
        spur_pct   = 0;
        iready_pct = 100;
        repeat (20) @(negedge clk);
        chk("random_progress", {31'h0, (n_xfer - xfer_start) > 200}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
